// File: rtl/flip_sequencer.sv
// rtl/flip_sequencer.sv - Othello move sequencer: 8-ray scan, flip writes and redraw requests.
// Optional FLIP_ANIM_EN adds a FLIP_HOLD pause of ANIM_DELAY cycles after each flip draw.
module flip_sequencer
`ifdef FLIP_ANIM_EN
  #(parameter logic [23:0] ANIM_DELAY = 24'd2_500_000)
`endif
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       check_only,
  input  logic       side,
  input  logic [2:0] pos_x,
  input  logic [2:0] pos_y,
  output logic [5:0] mem_addr,
  input  logic [1:0] mem_rdata,
  output logic       mem_we,
  output logic [1:0] mem_wdata,
  output logic       draw_req,
  output logic [2:0] draw_x,
  output logic [2:0] draw_y,
  input  logic       draw_ack,
  output logic       busy,
  output logic       done,
  output logic       legal,
  output logic [4:0] flip_count
);
  typedef enum logic [3:0] {
    S_IDLE, S_ORIG_RD, S_ORIG_EV, S_DIR_INIT, S_STEP, S_RD, S_EV,
    S_FLIP_WR, S_FLIP_DRAW, S_ORIG_WR, S_ORIG_DRAW, S_FIN
`ifdef FLIP_ANIM_EN
    , S_FLIP_HOLD
`endif
  } state_t;

  state_t             r_state, w_state_nxt, w_after_ray, w_flip_next;
  logic               r_chk, r_side;
  logic [2:0]         r_ox, r_oy, r_dir, r_run, r_left;
  logic signed [3:0]  r_cx, r_cy;
  logic [4:0]         r_count;
  logic signed [3:0]  w_dx, w_dy, w_nx, w_ny, w_fx, w_fy;
  logic               w_off, w_is_own, w_is_opp;
  logic [1:0]         w_own;
`ifdef FLIP_ANIM_EN
  logic [23:0]        r_hold;
`endif

  // Ray order N, NE, E, SE, S, SW, W, NW
  always_comb begin
    w_dx = 4'sd0;
    w_dy = 4'sd0;
    case (r_dir)
      3'd0: w_dy = -4'sd1;
      3'd1: begin w_dx = 4'sd1;  w_dy = -4'sd1; end
      3'd2: w_dx = 4'sd1;
      3'd3: begin w_dx = 4'sd1;  w_dy = 4'sd1;  end
      3'd4: w_dy = 4'sd1;
      3'd5: begin w_dx = -4'sd1; w_dy = 4'sd1;  end
      3'd6: w_dx = -4'sd1;
      default: begin w_dx = -4'sd1; w_dy = -4'sd1; end
    endcase
  end

  assign w_nx     = r_cx + w_dx;
  assign w_ny     = r_cy + w_dy;
  assign w_fx     = $signed({1'b0, r_ox}) + w_dx;
  assign w_fy     = $signed({1'b0, r_oy}) + w_dy;
  // From an on-board cell a single step lands in -1..8, so bit 3 flags off-board
  assign w_off    = w_nx[3] | w_ny[3];
  assign w_own    = r_side ? 2'b10 : 2'b01;
  assign w_is_own = (mem_rdata == w_own);
  assign w_is_opp = (mem_rdata == ~w_own);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_after_ray = S_DIR_INIT;
    if (r_dir == 3'd7)
      w_after_ray = (r_count != 5'd0 && !r_chk) ? S_ORIG_WR : S_FIN;
    w_flip_next = (r_left == 3'd1) ? w_after_ray : S_FLIP_WR;
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (start) w_state_nxt = S_ORIG_RD;
      S_ORIG_RD:   w_state_nxt = S_ORIG_EV;
      S_ORIG_EV:   w_state_nxt = (mem_rdata == 2'b01 || mem_rdata == 2'b10) ? S_FIN : S_DIR_INIT;
      S_DIR_INIT:  w_state_nxt = S_STEP;
      S_STEP:      w_state_nxt = w_off ? w_after_ray : S_RD;
      S_RD:        w_state_nxt = S_EV;
      S_EV: begin
        if (w_is_opp)                        w_state_nxt = S_STEP;
        else if (w_is_own && r_run != 3'd0)  w_state_nxt = r_chk ? w_after_ray : S_FLIP_WR;
        else                                 w_state_nxt = w_after_ray;
      end
      S_FLIP_WR:   w_state_nxt = S_FLIP_DRAW;
`ifdef FLIP_ANIM_EN
      S_FLIP_DRAW: if (draw_ack) w_state_nxt = S_FLIP_HOLD;
      S_FLIP_HOLD: if (r_hold == 24'd0) w_state_nxt = w_flip_next;
`else
      S_FLIP_DRAW: if (draw_ack) w_state_nxt = w_flip_next;
`endif
      S_ORIG_WR:   w_state_nxt = S_ORIG_DRAW;
      S_ORIG_DRAW: if (draw_ack) w_state_nxt = S_FIN;
      S_FIN:       w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_chk   <= 1'b0;
      r_side  <= 1'b0;
      r_ox    <= 3'd0;
      r_oy    <= 3'd0;
      r_dir   <= 3'd0;
      r_run   <= 3'd0;
      r_left  <= 3'd0;
      r_cx    <= 4'sd0;
      r_cy    <= 4'sd0;
      r_count <= 5'd0;
`ifdef FLIP_ANIM_EN
      r_hold  <= 24'd0;
`endif
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_chk   <= check_only;
          r_side  <= side;
          r_ox    <= pos_x;
          r_oy    <= pos_y;
          r_dir   <= 3'd0;
          r_count <= 5'd0;
        end
        S_DIR_INIT: begin
          r_cx  <= $signed({1'b0, r_ox});
          r_cy  <= $signed({1'b0, r_oy});
          r_run <= 3'd0;
        end
        S_STEP: if (!w_off) begin
          r_cx <= w_nx;
          r_cy <= w_ny;
        end
        S_EV: begin
          if (w_is_opp) begin
            r_run <= r_run + 3'd1;
          end else if (w_is_own && r_run != 3'd0) begin
            r_count <= r_count + {2'b00, r_run};
            r_left  <= r_run;
            r_cx    <= w_fx;
            r_cy    <= w_fy;
          end
        end
        S_FLIP_DRAW: if (draw_ack) begin
          r_left <= r_left - 3'd1;
          r_cx   <= w_nx;
          r_cy   <= w_ny;
`ifdef FLIP_ANIM_EN
          r_hold <= ANIM_DELAY - 24'd1;
`endif
        end
`ifdef FLIP_ANIM_EN
        S_FLIP_HOLD: r_hold <= r_hold - 24'd1;
`endif
        default: ;
      endcase
      // Every ray end except the origin check lands in DIR_INIT for the next direction
      if (w_state_nxt == S_DIR_INIT && r_state != S_ORIG_EV)
        r_dir <= r_dir + 3'd1;
    end
  end

  always_comb begin
    mem_addr  = {r_cy[2:0], r_cx[2:0]};
    mem_we    = 1'b0;
    mem_wdata = 2'b00;
    draw_req  = 1'b0;
    draw_x    = r_cx[2:0];
    draw_y    = r_cy[2:0];
    busy      = (r_state != S_IDLE) && (r_state != S_FIN);
    done      = (r_state == S_FIN);
    case (r_state)
      S_ORIG_RD: mem_addr = {r_oy, r_ox};
      S_FLIP_WR: begin
        mem_we    = 1'b1;
        mem_wdata = w_own;
      end
      S_ORIG_WR: begin
        mem_addr  = {r_oy, r_ox};
        mem_we    = 1'b1;
        mem_wdata = w_own;
      end
      S_FLIP_DRAW: draw_req = 1'b1;
      S_ORIG_DRAW: begin
        draw_req = 1'b1;
        draw_x   = r_ox;
        draw_y   = r_oy;
      end
      default: ;
    endcase
  end

  assign flip_count = r_count;
  assign legal      = (r_count != 5'd0);

endmodule

// File: tb/tb_flip_sequencer.sv
// tb/tb_flip_sequencer.sv - scoreboard bench for flip_sequencer with a rule-level move model.
module tb_flip_sequencer;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0, check_only = 1'b0, side = 1'b0;
  logic [2:0] pos_x = 3'd0, pos_y = 3'd0;
  logic [5:0] mem_addr;
  logic [1:0] mem_rdata = 2'b00;
  logic       mem_we;
  logic [1:0] mem_wdata;
  logic       draw_req;
  logic [2:0] draw_x, draw_y;
  logic       draw_ack = 1'b0;
  logic       busy, done, legal;
  logic [4:0] flip_count;

  flip_sequencer dut (
    .clk(clk), .reset_n(reset_n), .start(start), .check_only(check_only), .side(side),
    .pos_x(pos_x), .pos_y(pos_y), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .draw_req(draw_req), .draw_x(draw_x),
    .draw_y(draw_y), .draw_ack(draw_ack), .busy(busy), .done(done), .legal(legal),
    .flip_count(flip_count)
  );

  always #5 clk = ~clk;

  logic [1:0] board [64];
  always @(posedge clk) mem_rdata <= board[mem_addr];

  int n_checks = 0, n_pass = 0, done_count = 0;
  logic [7:0] exp_wr[$];
  logic [5:0] exp_draw[$];
  logic [5:0] exp_done[$];
  int DX[8] = '{0, 1, 1, 1, 0, -1, -1, -1};
  int DY[8] = '{-1, -1, 0, 1, 1, 1, 0, -1};

  bit ack_tied = 1'b0, ack_noise = 1'b0;
  int ack_delay = 0, ack_wait = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Draw engine: acks after ack_delay cycles of a pending request
  always @(posedge clk) begin
    #1;
    if (ack_tied) draw_ack = 1'b1;
    else if (draw_req) begin
      if (ack_wait >= ack_delay) draw_ack = 1'b1;
      else begin draw_ack = 1'b0; ack_wait++; end
    end else begin
      ack_wait = 0;
      draw_ack = ack_noise ? ($urandom_range(0, 2) == 0) : 1'b0;
    end
  end

  // Monitor: pops expectations whenever the DUT presents a write, a new draw, or done
  logic       pend = 1'b0;
  logic [2:0] hx = 3'd0, hy = 3'd0;
  always @(negedge clk) begin
    logic [7:0] ew;
    logic [5:0] ed;
    if (!reset_n) pend = 1'b0;
    else begin
      if (mem_we) begin
        if (exp_wr.size() == 0) check("wr_unexpected", 1, 0);
        else begin
          ew = exp_wr.pop_front();
          check("wr_addr", mem_addr, ew[5:0]);
          check("wr_data", mem_wdata, ew[7:6]);
        end
      end
      if (draw_req) begin
        if (pend) begin
          check("draw_hold_x", draw_x, hx);
          check("draw_hold_y", draw_y, hy);
          check("we_during_draw", mem_we, 0);
        end else if (exp_draw.size() == 0) check("draw_unexpected", 1, 0);
        else begin
          ed = exp_draw.pop_front();
          check("draw_x", draw_x, ed[5:3]);
          check("draw_y", draw_y, ed[2:0]);
          hx = draw_x;
          hy = draw_y;
        end
      end
      pend = draw_req && !draw_ack;
      if (done) begin
        done_count++;
        check("busy_at_done", busy, 0);
        if (exp_done.size() == 0) check("done_unexpected", 1, 0);
        else begin
          ed = exp_done.pop_front();
          check("legal", legal, ed[5]);
          check("flip_count", flip_count, ed[4:0]);
        end
      end
    end
  end

  // Rule-level model: walk each ray over opponent disks, bracketed by own disk
  task automatic model_move(input int px, input int py, input bit sd, input bit chk);
    int cnt, x, y, run;
    logic [1:0] own, opp;
    own = sd ? 2'b10 : 2'b01;
    opp = sd ? 2'b01 : 2'b10;
    cnt = 0;
    if (board[py*8+px] == 2'b01 || board[py*8+px] == 2'b10) begin
      exp_done.push_back(6'd0);
      return;
    end
    for (int d = 0; d < 8; d++) begin
      x = px + DX[d]; y = py + DY[d]; run = 0;
      while (x >= 0 && x < 8 && y >= 0 && y < 8 && board[y*8+x] == opp) begin
        run++; x += DX[d]; y += DY[d];
      end
      if (x >= 0 && x < 8 && y >= 0 && y < 8 && board[y*8+x] == own && run > 0) begin
        cnt += run;
        if (!chk)
          for (int k = 1; k <= run; k++) begin
            exp_wr.push_back({own, 6'((py + k*DY[d])*8 + px + k*DX[d])});
            exp_draw.push_back({3'(px + k*DX[d]), 3'(py + k*DY[d])});
          end
      end
    end
    if (cnt > 0 && !chk) begin
      exp_wr.push_back({own, 6'(py*8 + px)});
      exp_draw.push_back({3'(px), 3'(py)});
    end
    exp_done.push_back({cnt != 0, 5'(cnt)});
  endtask

  task automatic opening();
    for (int i = 0; i < 64; i++) board[i] = 2'b00;
    board[27] = 2'b10; board[36] = 2'b10; board[35] = 2'b01; board[28] = 2'b01;
  endtask

  task automatic do_move(input int px, input int py, input bit sd, input bit chk,
                         input bit glitch, output int lat);
    model_move(px, py, sd, chk);
    @(negedge clk);
    pos_x = 3'(px); pos_y = 3'(py); side = sd; check_only = chk; start = 1'b1;
    @(negedge clk);
    start = 1'b0; lat = 1;
    while (!done && lat < 4000) begin
      if (glitch && lat == 2) begin
        start = 1'b1; pos_x = ~pos_x; side = ~side; check_only = ~check_only;
      end else start = 1'b0;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    if (!done) check("done_timeout", lat, -1);
    @(negedge clk);
    check("queues_drained", exp_wr.size() + exp_draw.size() + exp_done.size(), 0);
    exp_wr.delete(); exp_draw.delete(); exp_done.delete();
  endtask

  initial begin
    int lat, r, px, py;
    for (int i = 0; i < 64; i++) board[i] = 2'b00;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_we", mem_we, 0);
    check("rst_draw_req", draw_req, 0);
    check("rst_flip_count", flip_count, 0);
    check("rst_legal", legal, 0);
    reset_n = 1'b1;

    opening();
    do_move(3, 2, 1'b0, 1'b1, 1'b0, lat);           // check-only opening move
    ack_tied = 1'b1;
    do_move(3, 2, 1'b0, 1'b0, 1'b0, lat);           // writes 27 then 19
    opening();
    do_move(3, 3, 1'b0, 1'b0, 1'b0, lat);           // occupied origin
    check("occupied_latency_le4", (lat <= 4) ? 1 : 0, 1);
    for (int i = 0; i < 64; i++) board[i] = 2'b00;
    do_move(0, 0, 1'b1, 1'b0, 1'b0, lat);           // empty board corner
    ack_tied = 1'b0; ack_delay = 5;
    opening();
    do_move(3, 2, 1'b0, 1'b0, 1'b0, lat);           // slow draw engine

    // Reset while a draw request is pending
    ack_delay = 50;
    model_move(3, 2, 1'b0, 1'b0);
    @(negedge clk);
    pos_x = 3'd3; pos_y = 3'd2; side = 1'b0; check_only = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; lat = 0;
    while (!draw_req && lat < 200) begin @(negedge clk); lat++; end
    check("reached_draw", draw_req, 1);
    #2 reset_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_draw_req", draw_req, 0);
    check("abort_we", mem_we, 0);
    check("abort_flip_count", flip_count, 0);
    check("abort_addr", mem_addr, 0);
    exp_wr.delete(); exp_draw.delete(); exp_done.delete();
    @(negedge clk); reset_n = 1'b1;
    ack_delay = 0;
    do_move(3, 2, 1'b0, 1'b1, 1'b0, lat);

    // Randomized boards, sides, modes, ack timing, noise and ignored mid-move starts
    ack_noise = 1'b1;
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 64; i++) begin
        r = $urandom_range(0, 9);
        board[i] = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      end
      px = $urandom_range(0, 7); py = $urandom_range(0, 7);
      if ($urandom_range(0, 9) < 7) board[py*8+px] = ($urandom_range(0, 3) == 0) ? 2'b11 : 2'b00;
      ack_tied = ($urandom_range(0, 3) == 0);
      ack_delay = $urandom_range(0, 3);
      do_move(px, py, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
              1'($urandom_range(0, 1)), lat);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
